// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: shared definitions for the memory-mapped UART.
//   Register offsets (addr[3:2]), STATUS bit indices, TX/RX FSM state
//   encodings, the minimum bit-period divider, the decoded bus request
//   struct and the divider clamp helper.
package mmio_uart_pkg;

  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_RXDATA  = 2'd1;
  localparam logic [1:0] UART_STATUS  = 2'd2;
  localparam logic [1:0] UART_BAUDDIV = 2'd3;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_VALID    = 2;
  localparam int ST_RX_OVERRUN  = 3;
  localparam int ST_TX_BUSY     = 4;
  localparam int ST_FRAME_ERR   = 5;
  localparam int ST_TX_OVERFLOW = 6;

  localparam logic [15:0] UART_DIV_MIN = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // One decoded, edge-qualified bus access.
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  off;
    logic [15:0] wdata;
  } mmio_req_t;

  // Dividers below the minimum would leave no room for a mid-bit sample.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < UART_DIV_MIN) ? UART_DIV_MIN : d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO, DEPTH entries (power of 2, >= 2).
//   clk, rst (async, active-high) | push/wdata: enqueue | pop: dequeue
//   rdata: head entry (combinational) | full, empty: occupancy flags
// A push while full is dropped unless a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][7:0] mem;
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end

endmodule

// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped UART on the CPU data-memory bus.
//   clk, rst (async, active-high)
//   mem_en/mem_we/mem_bs/addr/data_in: CPU access | data_out: registered load data
//   hit: combinational window decode | uart_rx: async serial in | uart_tx: serial out
// Register window (16 bytes at BASE_ADDR): TXDATA, RXDATA, STATUS, BAUDDIV.
// Build option: define MMIO_UART_RX_EN to include the receive path; without it
// RXDATA and the RX status bits read 0 and uart_rx is ignored.
module mmio_uart
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter logic [15:0] DIV_RESET = 16'd868,
  parameter int          TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [1:0]  mem_bs,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        hit,
  input  logic        uart_rx,
  output logic        uart_tx
);

  // ---- bus decode: act once per mem_en high period ----
  logic      acc, acc_q;
  mmio_req_t req;

  assign hit = addr[31:4] == BASE_ADDR[31:4];
  assign acc = mem_en & hit;

  always_ff @(posedge clk or posedge rst)
    if (rst) acc_q <= 1'b0;
    else     acc_q <= acc;

  always_comb begin
    req.rd    = acc & ~acc_q & ~mem_we;
    req.wr    = acc & ~acc_q &  mem_we;
    req.off   = addr[3:2];
    req.wdata = data_in[15:0];
  end

  logic unused_bits;
  assign unused_bits = ^{mem_bs, addr[1:0], data_in[31:16]};

  logic sts_wr;
  assign sts_wr = req.wr && req.off == UART_STATUS;

  // ---- TX FIFO ----
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  assign fifo_push = req.wr && req.off == UART_TXDATA;

  uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (req.wdata[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---- control registers ----
  logic [15:0] bauddiv;
  logic        tx_overflow;

  always_ff @(posedge clk or posedge rst)
    if (rst) bauddiv <= DIV_RESET;
    else if (req.wr && req.off == UART_BAUDDIV) bauddiv <= clamp_div(req.wdata);

  always_ff @(posedge clk or posedge rst)
    if (rst)                                      tx_overflow <= 1'b0;
    else if (fifo_push & fifo_full & ~fifo_pop)   tx_overflow <= 1'b1;
    else if (sts_wr & req.wdata[ST_TX_OVERFLOW])  tx_overflow <= 1'b0;

  // ---- TX FSM ----
  tx_state_e   tx_st, tx_nx;
  logic [15:0] tx_div, tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_sh;
  logic        tx_bit_end, tx_line;

  assign tx_bit_end = tx_cnt == tx_div - 16'd1;

  always_ff @(posedge clk or posedge rst)
    if (rst) tx_st <= TX_IDLE;
    else     tx_st <= tx_nx;

  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      TX_IDLE:  if (!fifo_empty) tx_nx = TX_START;
      TX_START: if (tx_bit_end) tx_nx = TX_DATA;
      TX_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_nx = TX_STOP;
      TX_STOP:  if (tx_bit_end) tx_nx = fifo_empty ? TX_IDLE : TX_START;
      default:  tx_nx = TX_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop = 1'b0;
    tx_line  = 1'b1;
    case (tx_st)
      TX_IDLE:  fifo_pop = !fifo_empty;
      TX_START: tx_line  = 1'b0;
      TX_DATA:  tx_line  = tx_sh[0];
      TX_STOP:  fifo_pop = tx_bit_end && !fifo_empty;
      default:  ;
    endcase
  end

  // Divider is captured with each byte so BAUDDIV writes never disturb a frame.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_div <= DIV_RESET;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
    end else if (fifo_pop) begin
      tx_div <= bauddiv;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= fifo_rdata;
    end else if (tx_st != TX_IDLE) begin
      if (tx_bit_end) begin
        tx_cnt <= '0;
        if (tx_st == TX_DATA) begin
          tx_sh  <= tx_sh >> 1;
          tx_idx <= tx_idx + 3'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end

  // Registered line output; reset forces idle-high without waiting for a clock.
  always_ff @(posedge clk or posedge rst)
    if (rst) uart_tx <= 1'b1;
    else     uart_tx <= tx_line;

  // ---- RX path ----
  logic       rx_valid, rx_overrun, frame_err;
  logic [7:0] rx_byte;

`ifdef MMIO_UART_RX_EN
  rx_state_e   rx_st, rx_nx;
  logic        rx_s1, rx_s2, rx_d;
  logic [15:0] rx_div, rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_sh;
  logic        rx_half_end, rx_bit_end, rx_done, rx_load, rx_pop;

  assign rx_pop      = req.rd && req.off == UART_RXDATA;
  assign rx_half_end = rx_cnt == (rx_div >> 1) - 16'd1;
  assign rx_bit_end  = rx_cnt == rx_div - 16'd1;

  // rx_d is one more stage so a falling edge is seen as (rx_d & ~rx_s2).
  always_ff @(posedge clk or posedge rst)
    if (rst) {rx_s1, rx_s2, rx_d} <= 3'b111;
    else     {rx_s1, rx_s2, rx_d} <= {uart_rx, rx_s1, rx_s2};

  always_ff @(posedge clk or posedge rst)
    if (rst) rx_st <= RX_IDLE;
    else     rx_st <= rx_nx;

  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      RX_IDLE:  if (rx_d & ~rx_s2) rx_nx = RX_START;
      RX_START: if (rx_half_end) rx_nx = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_nx = RX_STOP;
      RX_STOP:  if (rx_bit_end) rx_nx = RX_IDLE;
      default:  rx_nx = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_done = (rx_st == RX_STOP) && rx_bit_end;
    rx_load = rx_done & rx_s2;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_div <= DIV_RESET;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh  <= '0;
    end else begin
      case (rx_st)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_idx <= '0;
          if (rx_d & ~rx_s2) rx_div <= bauddiv;
        end
        RX_START: rx_cnt <= rx_half_end ? 16'd0 : rx_cnt + 16'd1;
        RX_DATA:
          if (rx_bit_end) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_idx <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        default: rx_cnt <= rx_bit_end ? 16'd0 : rx_cnt + 16'd1;
      endcase
    end

  // A new byte landing in the same cycle as a pop wins and is not an overrun.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rx_load) rx_byte <= rx_sh;

      if (rx_load)     rx_valid <= 1'b1;
      else if (rx_pop) rx_valid <= 1'b0;

      if (rx_load & rx_valid & ~rx_pop)            rx_overrun <= 1'b1;
      else if (sts_wr & req.wdata[ST_RX_OVERRUN])  rx_overrun <= 1'b0;

      if (rx_done & ~rx_s2)                        frame_err <= 1'b1;
      else if (sts_wr & req.wdata[ST_FRAME_ERR])   frame_err <= 1'b0;
    end
`else
  logic unused_rx;
  assign unused_rx  = uart_rx;
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign frame_err  = 1'b0;
  assign rx_byte    = '0;
`endif

  // ---- read mux and load data register ----
  logic [6:0]  status;
  logic [31:0] rdata;

  always_comb begin
    status                 = '0;
    status[ST_TX_FULL]     = fifo_full;
    status[ST_TX_EMPTY]    = fifo_empty;
    status[ST_RX_VALID]    = rx_valid;
    status[ST_RX_OVERRUN]  = rx_overrun;
    status[ST_TX_BUSY]     = tx_st != TX_IDLE;
    status[ST_FRAME_ERR]   = frame_err;
    status[ST_TX_OVERFLOW] = tx_overflow;
  end

  always_comb begin
    rdata = '0;
    case (req.off)
      UART_RXDATA:  rdata = {rx_valid, 23'b0, rx_byte};
      UART_STATUS:  rdata = {25'b0, status};
      UART_BAUDDIV: rdata = {16'b0, bauddiv};
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst)                              data_out <= '0;
    else if (req.rd)                      data_out <= rdata;
    else if (req.wr | (mem_en & ~hit))    data_out <= '0;

endmodule

// File: doc/mmio_uart.md
# mmio_uart

Memory-mapped UART peripheral responding to the CPU's data-memory bus (the `mem_en`/`mem_we`/`mem_bs`/`addr`/`data_in`/`data_out` access issued in the memory state). It is the responder end of the CPU's load/store interface. It decodes a 16-byte register window and serialises bytes through a TX FIFO onto `uart_tx`. It deserialises `uart_rx` into a one-byte holding register. It sits beside `data_mem`; the top level muxes `data_out` using `hit`.

## Interface
- `BASE_ADDR`, 32'h0000_0100, window base; must be 16-byte aligned.
- `DIV_RESET`, 16'd868, reset bit period in clocks (100 MHz / 115200).
- `TX_DEPTH`, 4, TX FIFO entries; must be a power of 2, at least 2.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mem_en`  in  1  access strobe; high for the memory state.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_bs`  in  2  access size; ignored, except that byte data is always taken from `data_in[7:0]`.
- `addr`  in  32  byte address.
- `data_in`  in  32  store data.
- `data_out`  out  32  registered load data.
- `hit`  out  1  combinational: `addr[31:4] == BASE_ADDR[31:4]`.
- `uart_rx`  in  1  asynchronous serial input.
- `uart_tx`  out  1  serial output, idle high.

## Operation
- Access definition:
  - An access occurs on any posedge with `mem_en & hit`.
  - An access is acted on once per `mem_en` high period: rising-edge detect of `mem_en & hit`. The CPU holds `mem_en` for a full memory state.
- Register map (offset `addr[3:2]`):
  - 0x0 TXDATA: a store pushes `data_in[7:0]`. Loads return 0.
  - 0x4 RXDATA: a load returns `{rx_valid, 23'b0, rx_byte}` and clears `rx_valid` (pop). Stores are ignored.
  - 0x8 STATUS, read: bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 rx_overrun, bit4 tx_busy, bit5 frame_err, bit6 tx_overflow. Bits 3, 5, 6 are sticky.
  - 0x8 STATUS, write: writing 1 to bit 3, 5 or 6 clears that bit.
  - 0xC BAUDDIV: read/write `[15:0]`. Written values below 4 are stored as 4.
- TX FIFO:
  - A push when full drops the byte and sets tx_overflow.
  - A push and a pop in the same cycle are both honoured.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: leaves when the FIFO is non-empty. It pops the head and latches BAUDDIV into the frame divider.
  - Each state lasts one bit period, which is the latched divider in clocks.
  - DATA shifts 8 bits, LSB first.
  - STOP drives 1. At the end of STOP the FSM goes directly to START if the FIFO is non-empty (back-to-back frames). Otherwise it returns to IDLE.
  - tx_busy = state ≠ IDLE.
- RX path:
  - `uart_rx` passes through a 2-flop synchroniser.
  - A falling edge in IDLE starts a half-bit wait.
  - If the line is still low after the half-bit wait, the FSM enters DATA. If it is high, it returns to IDLE (glitch rejected).
  - DATA takes 8 samples at bit mid-points. STOP then takes one sample.
  - Stop = 1: the byte loads `rx_byte` and sets `rx_valid`. If `rx_valid` was already 1 and no pop happens in the same cycle, rx_overrun is set and the new byte overwrites the old one.
  - Stop = 0: the byte is discarded and frame_err is set.
  - The divider is latched at start detection.
  - A pop and a load in the same cycle: the load wins, `rx_valid` stays 1, and rx_overrun is not set.
- Non-hit accesses: ignored, and `data_out` = 0.
- A BAUDDIV write during a frame takes effect from the next frame.

## Timing
- Reset values:
  - `uart_tx` = 1, `data_out` = 0.
  - BAUDDIV = `DIV_RESET`.
  - FIFO empty, all status bits 0.
  - TX and RX FSMs in IDLE.
- Reset mid-frame aborts immediately. `uart_tx` goes high asynchronously.
- Load latency: `data_out` is valid from the posedge after the access. It holds until the next access; it returns to 0 on a non-hit access. The CPU write state samples it.
- Store effect: visible in STATUS on the load one posedge after the store.
- TX start latency:
  - Push into an empty FIFO while IDLE → `uart_tx` falls on the 2nd posedge after the store posedge.
  - Frame length = 10 × divider clocks.
- RX: `rx_valid` rises one clock after the stop-bit mid-sample. The synchroniser adds 2 clocks of input latency.

## Configuration
- `MMIO_UART_RX_EN`, defined: the RX path, RXDATA and status bits 2, 3, 5 are present.
- `MMIO_UART_RX_EN`, undefined:
  - No RX logic is synthesised and `uart_rx` is ignored.
  - RXDATA reads 0, and status bits 2, 3, 5 read 0.

## Structure
- Shared package `mmio_uart_pkg`:
  - register offsets (`UART_TXDATA`, `UART_RXDATA`, `UART_STATUS`, `UART_BAUDDIV`)
  - status bit indices
  - TX/RX FSM state encodings
  - minimum divider constant (4)
- One sub-module: `uart_tx_fifo` (synchronous FIFO, `TX_DEPTH` deep, 8 bits wide, full/empty flags). The RX and TX FSMs stay in `mmio_uart`.

## Test plan
- Reset → `uart_tx` = 1, a load of STATUS = 0x2, a load of BAUDDIV = 868.
- BAUDDIV = 4, store 0x55 to TXDATA → `uart_tx` pattern 0,1,0,1,0,1,0,1,0,1,1, each level lasting 4 clocks; tx_busy = 1 during the frame.
- BAUDDIV = 4, five stores back-to-back (0x01–0x05) with `TX_DEPTH` = 4 → all five frames sent contiguously (the first byte is popped to the shifter before the 5th push) with no idle gap; tx_overflow = 0. A 6th and 7th store while the FIFO is full sets tx_overflow.
- Drive an RX frame of 0xA3 at divider 8 → a load of RXDATA = 0x8000_00A3, and a second load returns 0x0000_00A3 with bit 31 = 0.
- Two RX frames (0x11, 0x22) without a pop → RXDATA = 0x22, rx_overrun = 1. Storing 0x8 to STATUS clears it.
- RX frame with stop bit = 0 → rx_valid stays 0 and frame_err = 1. Asserting `rst` mid-TX-frame → `uart_tx` = 1 at once and the FIFO is empty.
